// File: rtl/shared_divider_ctrl_if.sv
// Request/grant and result bundle between two client datapaths and the
// shared divider. master = client side, slave = divider controller side.
interface shared_divider_ctrl_if #(
    parameter int WIDTH = 8
);
    logic [1:0]       req;
    logic [WIDTH-1:0] dividend0;
    logic [WIDTH-1:0] divisor0;
    logic [WIDTH-1:0] dividend1;
    logic [WIDTH-1:0] divisor1;
    logic [1:0]       gnt;
    logic             busy;
    logic             done;
    logic             done_id;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    modport master (
        output req, dividend0, divisor0, dividend1, divisor1,
        input  gnt, busy, done, done_id, quotient, remainder, div_zero
    );

    modport slave (
        input  req, dividend0, divisor0, dividend1, divisor1,
        output gnt, busy, done, done_id, quotient, remainder, div_zero
    );
endinterface

// File: rtl/shared_divider_ctrl.sv
// Shared restoring divider with a two-requester arbiter and sequencer.
// Ports: clk, rst (async, active-high), bus (slave modport): req[1:0],
//   dividend0/1, divisor0/1 in; gnt[1:0], busy, done, done_id,
//   quotient, remainder, div_zero out (all registered).
// Build option: define RR_ARB_EN for round-robin arbitration; otherwise
//   requester 0 has fixed priority.
module shared_divider_ctrl #(
    parameter int WIDTH = 8
) (
    input logic                  clk,
    input logic                  rst,
    shared_divider_ctrl_if.slave bus
);
    localparam int SW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state;
    state_t state_n;

    logic [WIDTH:0]   rem_q;
    logic [WIDTH-1:0] dvd_q;
    logic [WIDTH-1:0] dsr_q;
    logic [SW-1:0]    step_q;
    logic             id_q;

    logic [1:0]       gnt_q;
    logic             busy_q;
    logic             done_q;
    logic             done_id_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] rmd_q;
    logic             dz_q;

    logic             accept;
    logic             win;
    logic [WIDTH-1:0] sel_dvd;
    logic [WIDTH-1:0] sel_dsr;
    logic             sel_zero;

    logic [WIDTH:0]   shifted;
    logic             ge;
    logic [WIDTH:0]   rem_n;
    logic [WIDTH-1:0] dvd_n;
    logic             last_step;

    // After every restoring step the partial remainder is below the
    // divisor, so its extra top bit only exists for the compare carry.
    logic unused_rem_msb;
    assign unused_rem_msb = rem_q[WIDTH];

`ifdef RR_ARB_EN
    logic last_q;

    // Tie goes to whichever requester was not served last.
    always_comb begin
        win = 1'b0;
        if (&bus.req) win = ~last_q;
        else          win = ~bus.req[0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)         last_q <= 1'b1;
        else if (accept) last_q <= win;
    end
`else
    always_comb begin
        win = ~bus.req[0];
    end
`endif

    assign accept   = (state == IDLE) && (|bus.req);
    assign sel_dvd  = win ? bus.dividend1 : bus.dividend0;
    assign sel_dsr  = win ? bus.divisor1  : bus.divisor0;
    assign sel_zero = (sel_dsr == '0);

    // One restoring step: shift {rem, dvd} left, trial-subtract divisor.
    always_comb begin
        shifted   = {rem_q[WIDTH-1:0], dvd_q[WIDTH-1]};
        ge        = (shifted >= {1'b0, dsr_q});
        rem_n     = ge ? (shifted - {1'b0, dsr_q}) : shifted;
        dvd_n     = {dvd_q[WIDTH-2:0], ge};
        last_step = (step_q == SW'(WIDTH - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (accept) state_n = sel_zero ? DONE : RUN;
            end
            RUN: begin
                if (last_step) state_n = DONE;
            end
            DONE: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q     <= '0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            step_q    <= '0;
            id_q      <= 1'b0;
            gnt_q     <= 2'b00;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            quo_q     <= '0;
            rmd_q     <= '0;
            dz_q      <= 1'b0;
        end else begin
            gnt_q  <= accept ? (win ? 2'b10 : 2'b01) : 2'b00;
            busy_q <= (state_n != IDLE);
            done_q <= (state_n == DONE);

            if (accept) begin
                dvd_q  <= sel_dvd;
                dsr_q  <= sel_dsr;
                rem_q  <= '0;
                step_q <= '0;
                id_q   <= win;
                // Divide by zero skips RUN; results publish with the grant.
                if (sel_zero) begin
                    quo_q     <= '1;
                    rmd_q     <= sel_dvd;
                    dz_q      <= 1'b1;
                    done_id_q <= win;
                end
            end

            if (state == RUN) begin
                rem_q  <= rem_n;
                dvd_q  <= dvd_n;
                step_q <= step_q + 1'b1;
                if (last_step) begin
                    quo_q     <= dvd_n;
                    rmd_q     <= rem_n[WIDTH-1:0];
                    dz_q      <= 1'b0;
                    done_id_q <= id_q;
                end
            end
        end
    end

    assign bus.gnt       = gnt_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.done_id   = done_id_q;
    assign bus.quotient  = quo_q;
    assign bus.remainder = rmd_q;
    assign bus.div_zero  = dz_q;
endmodule

// File: tb/tb_shared_divider_ctrl.sv
// Directed bench for shared_divider_ctrl (WIDTH=8): latency, results,
// divide by zero, arbitration, mid-op reset and operand sampling.
module tb_shared_divider_ctrl;
    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;
    logic last_srv;

    shared_divider_ctrl_if #(.WIDTH(8)) bus ();

    shared_divider_ctrl #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".gnt"}, {30'd0, bus.gnt}, 32'd0);
        chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, ".done"}, {31'd0, bus.done}, 32'd0);
        chk({tag, ".id"}, {31'd0, bus.done_id}, 32'd0);
        chk({tag, ".quo"}, {24'd0, bus.quotient}, 32'd0);
        chk({tag, ".rem"}, {24'd0, bus.remainder}, 32'd0);
        chk({tag, ".dz"}, {31'd0, bus.div_zero}, 32'd0);
    endtask

    // Accept (req=r), then req=ra for the cycle after the grant, then rb.
    // lat=0 means divide by zero (done with the grant).
    task automatic do_op(input string tag, input logic [1:0] r,
                         input logic [1:0] ra, input logic [1:0] rb,
                         input logic [1:0] egnt, input int lat,
                         input logic [7:0] eq, input logic [7:0] er,
                         input logic eid, input logic edz, input bit scr);
        int n;
        bus.req = r;
        tick;
        chk({tag, ".gnt"}, {30'd0, bus.gnt}, {30'd0, egnt});
        chk({tag, ".busy"}, {31'd0, bus.busy}, 32'd1);
        last_srv = eid;
        bus.req = ra;
        if (scr) begin
            bus.dividend0 = 8'd200;
            bus.divisor0  = 8'd3;
            bus.dividend1 = 8'd201;
            bus.divisor1  = 8'd4;
        end
        n = 0;
        if (lat != 0) begin
            tick;
            chk({tag, ".gnt1"}, {30'd0, bus.gnt}, 32'd0);
            bus.req = rb;
            n = 1;
            while (bus.done !== 1'b1 && n < 40) begin
                tick;
                n++;
            end
        end
        chk({tag, ".lat"}, n, lat);
        chk({tag, ".done"}, {31'd0, bus.done}, 32'd1);
        chk({tag, ".quo"}, {24'd0, bus.quotient}, {24'd0, eq});
        chk({tag, ".rem"}, {24'd0, bus.remainder}, {24'd0, er});
        chk({tag, ".id"}, {31'd0, bus.done_id}, {31'd0, eid});
        chk({tag, ".dz"}, {31'd0, bus.div_zero}, {31'd0, edz});
        bus.req = rb;
        tick;
        chk({tag, ".done0"}, {31'd0, bus.done}, 32'd0);
        chk({tag, ".idle"}, {31'd0, bus.busy}, 32'd0);
        chk({tag, ".hold"}, {24'd0, bus.quotient}, {24'd0, eq});
    endtask

    initial begin
        logic w;
        n_chk     = 0;
        n_pass    = 0;
        last_srv  = 1'b1;
        rst       = 1'b1;
        bus.req   = 2'b00;
        bus.dividend0 = 8'd0;
        bus.divisor0  = 8'd0;
        bus.dividend1 = 8'd0;
        bus.divisor1  = 8'd0;
        tick;
        tick;
        chk_zero("reset");
        rst = 1'b0;
        tick;

        bus.dividend0 = 8'd100;
        bus.divisor0  = 8'd7;
        do_op("d100_7", 2'b01, 2'b00, 2'b00, 2'b01, 8,
              8'd14, 8'd2, 1'b0, 1'b0, 1'b0);

        bus.dividend1 = 8'd255;
        bus.divisor1  = 8'd1;
        do_op("d255_1", 2'b10, 2'b00, 2'b00, 2'b10, 8,
              8'd255, 8'd0, 1'b1, 1'b0, 1'b0);

        bus.dividend0 = 8'd5;
        bus.divisor0  = 8'd9;
        do_op("d5_9", 2'b01, 2'b00, 2'b00, 2'b01, 8,
              8'd0, 8'd5, 1'b0, 1'b0, 1'b0);

        bus.dividend0 = 8'd37;
        bus.divisor0  = 8'd0;
        do_op("dz37", 2'b01, 2'b00, 2'b00, 2'b01, 0,
              8'hFF, 8'd37, 1'b0, 1'b1, 1'b0);

        // Both requesters pending; the winner drops req for one cycle.
        bus.dividend0 = 8'd50;
        bus.divisor0  = 8'd5;
        bus.dividend1 = 8'd50;
        bus.divisor1  = 8'd6;
        for (int i = 0; i < 4; i++) begin
`ifdef RR_ARB_EN
            w = ~last_srv;
`else
            w = 1'b0;
`endif
            do_op($sformatf("arb%0d", i), 2'b11,
                  w ? 2'b01 : 2'b10, 2'b11,
                  w ? 2'b10 : 2'b01, 8,
                  w ? 8'd8 : 8'd10, w ? 8'd2 : 8'd0,
                  w, 1'b0, 1'b0);
        end
        bus.req = 2'b00;
        tick;
        chk("arb.noacc", {30'd0, bus.gnt}, 32'd0);

        // Reset in RUN step 3 of 100/7.
        bus.dividend0 = 8'd100;
        bus.divisor0  = 8'd7;
        bus.req = 2'b01;
        tick;
        chk("rst.gnt", {30'd0, bus.gnt}, 32'd1);
        bus.req = 2'b00;
        tick;
        tick;
        tick;
        rst = 1'b1;
        #1;
        chk_zero("rst.async");
        tick;
        chk_zero("rst.hold");
        rst = 1'b0;
        last_srv = 1'b1;
        tick;
        chk("rst.nodone", {31'd0, bus.done}, 32'd0);

        // Operands scrambled right after the accepting edge.
        do_op("fresh", 2'b01, 2'b00, 2'b00, 2'b01, 8,
              8'd14, 8'd2, 1'b0, 1'b0, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
